// File: rtl/store_narrow_pkg.sv
// Shared encodings for the narrow store unit.
// Size codes and FSM state type used by store_narrow and its lane shifter.
package store_narrow_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10
  } state_t;

endpackage

// File: rtl/store_lane_shift.sv
// Narrows store data to its size and positions it on an 8-byte lane window.
// Illegal sizes produce an empty mask and zero data.
module store_lane_shift
  import store_narrow_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  output logic [7:0]  mask,
  output logic [63:0] wide
);

  logic [3:0]  nmask;
  logic [31:0] narrow;

  always_comb begin
    nmask  = 4'b0000;
    narrow = 32'h0;
    unique case (1'b1)
      (size == SZ_BYTE): begin
        nmask  = 4'b0001;
        narrow = {24'h0, data[7:0]};
      end
      (size == SZ_HALF): begin
        nmask  = 4'b0011;
        narrow = {16'h0, data[15:0]};
      end
      (size == SZ_WORD): begin
        nmask  = 4'b1111;
        narrow = data;
      end
      (size == SZ_ILL): begin
        nmask  = 4'b0000;
        narrow = 32'h0;
      end
    endcase
    mask = {4'b0000, nmask} << offset;
    wide = {32'h0, narrow} << {offset, 3'b000};
  end

endmodule

// File: rtl/store_narrow.sv
// Misaligned store unit: splits a byte/half/word store into one or two
// word-aligned memory write beats with byte enables.
module store_narrow
  import store_narrow_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_data,
  input  logic [1:0]        in_size,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              done,
  output logic              err
);

  state_t            state;
  logic [7:0]        mask;
  logic [63:0]       wide;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] hi_addr;
  logic [31:0]       hi_wdata;
  logic [3:0]        hi_be;
  logic              accept;

  store_lane_shift u_shift (
    .size   (in_size),
    .offset (in_addr[1:0]),
    .data   (in_data),
    .mask   (mask),
    .wide   (wide)
  );

  assign base     = {in_addr[ADDR_W-1:2], 2'b00};
  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  // The upper beat is captured at acceptance so BEAT1 needs no recompute.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      mem_be    <= 4'b0000;
      hi_addr   <= '0;
      hi_wdata  <= 32'h0;
      hi_be     <= 4'b0000;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_size == SZ_ILL) begin
              err <= 1'b1;
            end else begin
              state     <= BEAT0;
              mem_req   <= 1'b1;
              mem_addr  <= base;
              mem_be    <= mask[3:0];
              mem_wdata <= wide[31:0];
              hi_addr   <= base + ADDR_W'(4);
              hi_be     <= mask[7:4];
              hi_wdata  <= wide[63:32];
            end
          end
        end
        BEAT0: begin
          if (mem_ack) begin
            if (hi_be != 4'b0000) begin
              state     <= BEAT1;
              mem_addr  <= hi_addr;
              mem_be    <= hi_be;
              mem_wdata <= hi_wdata;
            end else begin
              state     <= IDLE;
              mem_req   <= 1'b0;
              mem_addr  <= '0;
              mem_be    <= 4'b0000;
              mem_wdata <= 32'h0;
              done      <= 1'b1;
            end
          end
        end
        BEAT1: begin
          if (mem_ack) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0;
            done      <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_narrow.sv
// Self-checking bench for store_narrow against a byte-level memory model.
// Directed corner stores followed by randomized stores with random stalls.
module tb_store_narrow;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       in_data;
  logic [1:0]        in_size;
  logic              mem_req;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              done;
  logic              err;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  beat_t exp_q[$];

  always #5 clk = ~clk;

  store_narrow #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_size   (in_size),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each stored byte lands at addr+k; bytes sharing a word form one beat.
  task automatic model(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz);
    int    n;
    beat_t cur;
    logic [31:0] ba;
    logic [31:0] wa;
    int    lane;
    exp_q.delete();
    if (sz == 2'b11) return;
    n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    cur = '0;
    for (int k = 0; k < n; k++) begin
      ba   = a + k;
      wa   = ba & ~32'h3;
      lane = int'(ba[1:0]);
      if (k == 0) begin
        cur.addr = wa;
      end else if (wa != cur.addr) begin
        exp_q.push_back(cur);
        cur      = '0;
        cur.addr = wa;
      end
      cur.be[lane]          = 1'b1;
      cur.wdata[8*lane +: 8] = d[8*k +: 8];
    end
    exp_q.push_back(cur);
  endtask

  task automatic chk_beat(input string tag, input beat_t b);
    chk({tag, "_req"}, 64'(mem_req), 64'(1'b1));
    chk({tag, "_addr"}, 64'(mem_addr), 64'(b.addr));
    chk({tag, "_be"}, 64'(mem_be), 64'(b.be));
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'(b.wdata));
    chk({tag, "_done"}, 64'(done), 64'(1'b0));
  endtask

  task automatic run_store(input string tag, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] sz,
                           input int stall);
    model(a, d, sz);
    @(negedge clk);
    chk({tag, "_ready"}, 64'(in_ready), 64'(1'b1));
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_size  = sz;
    mem_ack  = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    if (sz == 2'b11) begin
      chk({tag, "_err"}, 64'(err), 64'(1'b1));
      chk({tag, "_ill_req"}, 64'(mem_req), 64'(1'b0));
      chk({tag, "_ill_ready"}, 64'(in_ready), 64'(1'b1));
      @(negedge clk);
      chk({tag, "_err_clr"}, 64'(err), 64'(1'b0));
      chk({tag, "_ill_req2"}, 64'(mem_req), 64'(1'b0));
      return;
    end
    chk({tag, "_busy"}, 64'(in_ready), 64'(1'b0));
    foreach (exp_q[i]) begin
      chk_beat($sformatf("%s_b%0d", tag, i), exp_q[i]);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk_beat($sformatf("%s_b%0d_stall", tag, i), exp_q[i]);
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
    end
    chk({tag, "_done"}, 64'(done), 64'(1'b1));
    chk({tag, "_idle_req"}, 64'(mem_req), 64'(1'b0));
    chk({tag, "_idle_ready"}, 64'(in_ready), 64'(1'b1));
    @(negedge clk);
    chk({tag, "_done_clr"}, 64'(done), 64'(1'b0));
  endtask

  initial begin
    logic [1:0] rsz;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = 32'h0;
    in_size  = 2'b00;
    mem_ack  = 1'b0;

    @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'(1'b1));
    chk("rst_req", 64'(mem_req), 64'(1'b0));
    chk("rst_addr", 64'(mem_addr), 64'(0));
    chk("rst_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_be", 64'(mem_be), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    rst = 1'b0;

    // Stray ack while idle must do nothing.
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_req", 64'(mem_req), 64'(1'b0));
    chk("stray_done", 64'(done), 64'(1'b0));
    chk("stray_ready", 64'(in_ready), 64'(1'b1));

    run_store("byte1003", 32'h0000_1003, 32'hAABB_CCDD, 2'b00, 0);
    chk("byte1003_ref_be", 64'(exp_q[0].be), 64'(4'b1000));
    run_store("half2002", 32'h0000_2002, 32'h1234_5678, 2'b01, 0);
    chk("half2002_ref_wd", 64'(exp_q[0].wdata), 64'(32'h5678_0000));
    run_store("word3001", 32'h0000_3001, 32'h1122_3344, 2'b10, 0);
    chk("word3001_nbeats", 64'(exp_q.size()), 64'(2));
    run_store("halfwrap", 32'hFFFF_FFFF, 32'hCAFE_BEEF, 2'b01, 1);
    chk("halfwrap_b1addr", 64'(exp_q[1].addr), 64'(0));
    run_store("stall5", 32'h0000_4002, 32'hDEAD_BEEF, 2'b10, 5);
    run_store("illegal", 32'h0000_5000, 32'h0BAD_F00D, 2'b11, 0);
    run_store("word_al", 32'h0000_6000, 32'h8765_4321, 2'b10, 0);

    // Reset during the second beat of a split store.
    model(32'h0000_3001, 32'h1122_3344, 2'b10);
    @(negedge clk);
    in_valid = 1'b1;
    in_addr  = 32'h0000_3001;
    in_data  = 32'h1122_3344;
    in_size  = 2'b10;
    @(negedge clk);
    in_valid = 1'b0;
    chk_beat("rstb_b0", exp_q[0]);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk_beat("rstb_b1", exp_q[1]);
    #2 rst = 1'b1;
    #1;
    chk("rstb_req", 64'(mem_req), 64'(1'b0));
    chk("rstb_ready", 64'(in_ready), 64'(1'b1));
    chk("rstb_be", 64'(mem_be), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rstb_no_done", 64'(done), 64'(1'b0));
      chk("rstb_no_req", 64'(mem_req), 64'(1'b0));
    end
    mem_ack = 1'b0;

    for (int t = 0; t < 60; t++) begin
      rsz = 2'($urandom_range(0, 3));
      run_store($sformatf("rnd%0d", t), $urandom, $urandom, rsz,
                int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
